// File: rtl/branch_sequencer_pkg.sv
// Shared CPU control definitions: control-step state codes, opcodes,
// CON flip-flop condition codes and the strobe bundle used by the sequencer.
package branch_sequencer_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE = 4'd0;
  localparam state_t S_T0   = 4'd1;
  localparam state_t S_T1   = 4'd2;
  localparam state_t S_T1W  = 4'd3;
  localparam state_t S_T2   = 4'd4;
  localparam state_t S_T3   = 4'd5;
  localparam state_t S_T4   = 4'd6;
  localparam state_t S_T5   = 4'd7;
  localparam state_t S_T6   = 4'd8;

  localparam int unsigned WAIT_CNT_W = 8;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_JR   = 5'b10011,
    OP_BR   = 5'b10010,
    OP_HALT = 5'b11011
  } opcode_t;

  // Condition field C2[1:0] of a branch, as decoded by the CON flip-flop.
  typedef enum logic [1:0] {
    CC_ZERO     = 2'b00,
    CC_NONZERO  = 2'b01,
    CC_POSITIVE = 2'b10,
    CC_NEGATIVE = 2'b11
  } cond_code_t;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic z_lo_out;
    logic pc_in;
    logic read;
    logic md_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic done;
    logic other_op;
    logic mem_err;
  } strobes_t;

  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Reference evaluation of a condition code against a bus value's zero/sign flags.
  function automatic logic cond_met(input cond_code_t cc, input logic is_zero,
                                    input logic is_neg);
    logic r;
    case (cc)
      CC_ZERO:     r = is_zero;
      CC_NONZERO:  r = !is_zero;
      CC_POSITIVE: r = !is_zero && !is_neg;
      default:     r = is_neg;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_sequencer.sv
// Control-step sequencer: fetch T0-T2 with bounded memory wait, then a
// conditional branch T3-T6 or a one-cycle hand-off for any other opcode.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter logic [4:0]  BR_OPCODE   = OP_BR,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       mem_rdy,
  input  logic [4:0] ir_opcode,
  input  logic       con_out,
  output logic       pc_out,
  output logic       mar_in,
  output logic       inc_pc,
  output logic       z_in,
  output logic       z_lo_out,
  output logic       pc_in,
  output logic       read,
  output logic       md_in,
  output logic       mdr_in,
  output logic       mdr_out,
  output logic       ir_in,
  output logic       gra,
  output logic       r_out,
  output logic       con_in,
  output logic       y_in,
  output logic       c_out,
  output logic       alu_add,
  output logic       busy,
  output logic       done,
  output logic       other_op,
  output logic       mem_err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  generate
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("branch_sequencer: MEM_TIMEOUT must lie in 1..255");
    end
  endgenerate

  state_t                  state;
  state_t                  next_state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    wait_hit;
  logic                    is_branch;
  strobes_t                strb;

  assign wait_hit  = (wait_cnt == TIMEOUT_CNT);
  assign is_branch = (ir_opcode == BR_OPCODE);

  // State register and wait counter; the counter is only non-zero inside T1W.
  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_T1W && !mem_rdy && !wait_hit) begin
        wait_cnt <= sat_inc(wait_cnt);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = start ? S_T0 : S_IDLE;
      S_T0:    next_state = S_T1;
      S_T1:    next_state = S_T1W;
      S_T1W: begin
        // Ready wins over timeout when both land in the same cycle.
        if (mem_rdy)       next_state = S_T2;
        else if (wait_hit) next_state = S_IDLE;
        else               next_state = S_T1W;
      end
      S_T2:    next_state = S_T3;
      S_T3:    next_state = is_branch ? S_T4 : S_IDLE;
      S_T4:    next_state = S_T5;
      S_T5:    next_state = S_T6;
      S_T6:    next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    strb = '0;
    case (state)
      S_T0: begin
        strb.pc_out = 1'b1;
        strb.mar_in = 1'b1;
        strb.inc_pc = 1'b1;
        strb.z_in   = 1'b1;
      end
      S_T1: begin
        strb.z_lo_out = 1'b1;
        strb.pc_in    = 1'b1;
        strb.read     = 1'b1;
      end
      S_T1W: begin
        strb.read    = 1'b1;
        strb.md_in   = 1'b1;
        strb.mdr_in  = 1'b1;
        strb.mem_err = !mem_rdy && wait_hit;
      end
      S_T2: begin
        strb.mdr_out = 1'b1;
        strb.ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_branch) begin
          strb.gra    = 1'b1;
          strb.r_out  = 1'b1;
          strb.con_in = 1'b1;
        end else begin
          strb.other_op = 1'b1;
          strb.done     = 1'b1;
        end
      end
      S_T4: begin
        strb.pc_out = 1'b1;
        strb.y_in   = 1'b1;
      end
      S_T5: begin
        strb.c_out   = 1'b1;
        strb.alu_add = 1'b1;
        strb.z_in    = 1'b1;
      end
      S_T6: begin
        // CON was latched at the end of T3; it alone decides the PC load.
        strb.z_lo_out = 1'b1;
        strb.pc_in    = con_out;
        strb.done     = 1'b1;
      end
      default: strb = '0;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign pc_out   = strb.pc_out;
  assign mar_in   = strb.mar_in;
  assign inc_pc   = strb.inc_pc;
  assign z_in     = strb.z_in;
  assign z_lo_out = strb.z_lo_out;
  assign pc_in    = strb.pc_in;
  assign read     = strb.read;
  assign md_in    = strb.md_in;
  assign mdr_in   = strb.mdr_in;
  assign mdr_out  = strb.mdr_out;
  assign ir_in    = strb.ir_in;
  assign gra      = strb.gra;
  assign r_out    = strb.r_out;
  assign con_in   = strb.con_in;
  assign y_in     = strb.y_in;
  assign c_out    = strb.c_out;
  assign alu_add  = strb.alu_add;
  assign done     = strb.done;
  assign other_op = strb.other_op;
  assign mem_err  = strb.mem_err;

endmodule
